// File: rtl/switch_box_pkg.sv
// Shared constants and types for the switch box routing element.
package switch_box_pkg;

  localparam int unsigned SIDE_N = 0;
  localparam int unsigned SIDE_E = 1;
  localparam int unsigned SIDE_S = 2;
  localparam int unsigned SIDE_W = 3;

  localparam int unsigned CFG_BITS_PER_TRACK = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_OFF = 2'd3;

endpackage

// File: rtl/switch_box_element_cfg_if.sv
// Track buses and configuration-chain signals of one switch box.
interface switch_box_element_cfg_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] north_in;
  logic [W-1:0] east_in;
  logic [W-1:0] south_in;
  logic [W-1:0] west_in;
  logic [W-1:0] north_out;
  logic [W-1:0] east_out;
  logic [W-1:0] south_out;
  logic [W-1:0] west_out;
  logic         cfg_en;
  logic         cfg_in;
  logic         cfg_out;
  logic         cfg_load;
  logic         cfg_full;
  logic         cfg_err;

  modport master (
    output north_in, east_in, south_in, west_in,
    output cfg_en, cfg_in, cfg_load,
    input  north_out, east_out, south_out, west_out,
    input  cfg_out, cfg_full, cfg_err
  );

  modport slave (
    input  north_in, east_in, south_in, west_in,
    input  cfg_en, cfg_in, cfg_load,
    output north_out, east_out, south_out, west_out,
    output cfg_out, cfg_full, cfg_err
  );
endinterface

// File: rtl/switch_box_track_mux.sv
// Per-track 3:1 selector with an OFF code; one instance serves a whole output side.
module switch_box_track_mux
  import switch_box_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  sel_t [W-1:0] sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    for (int unsigned t = 0; t < W; t++) begin
      case (sel[t])
        2'd0:    y[t] = in0[t];
        2'd1:    y[t] = in1[t];
        2'd2:    y[t] = in2[t];
        SEL_OFF: y[t] = 1'b0;
        default: y[t] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/switch_box_element_cfg.sv
// Switch box with scan-loaded shadow config committed atomically to the active config.
// Optional registered outputs: define SWITCH_BOX_REG_OUT_EN.
module switch_box_element_cfg
  import switch_box_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input logic                      clk,
  input logic                      rst,
  switch_box_element_cfg_if.slave  bus
);

  localparam int unsigned      NBITS = CFG_BITS_PER_TRACK * W;
  localparam int unsigned      CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0]    FULL  = CW'(NBITS);

  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] active;
  logic [CW-1:0]    count;
  logic             err;
  logic             full;
  logic             commit;

  assign full   = (count == FULL);
  assign commit = bus.cfg_load && full;

  // Commit sees pre-shift shadow and pre-increment count; a same-cycle shift counts toward the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '1;
      active <= '1;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (bus.cfg_en)
        shadow <= {shadow[NBITS-2:0], bus.cfg_in};
      if (commit)
        active <= shadow;
      if (bus.cfg_load && !full)
        err <= 1'b1;
      if (commit)
        count <= bus.cfg_en ? CW'(1) : '0;
      else if (bus.cfg_en && !full)
        count <= count + CW'(1);
    end
  end

  sel_t [3:0][W-1:0] sel_side;

  always_comb begin
    sel_side = '1;
    for (int unsigned d = 0; d < 4; d++)
      for (int unsigned t = 0; t < W; t++)
        sel_side[d][t] = active[CFG_BITS_PER_TRACK*t + 2*d +: 2];
  end

  logic [3:0][W-1:0] route;

  switch_box_track_mux #(.W(W)) u_mux_n (
    .in0(bus.east_in), .in1(bus.south_in), .in2(bus.west_in),
    .sel(sel_side[SIDE_N]), .y(route[SIDE_N])
  );
  switch_box_track_mux #(.W(W)) u_mux_e (
    .in0(bus.south_in), .in1(bus.west_in), .in2(bus.north_in),
    .sel(sel_side[SIDE_E]), .y(route[SIDE_E])
  );
  switch_box_track_mux #(.W(W)) u_mux_s (
    .in0(bus.west_in), .in1(bus.north_in), .in2(bus.east_in),
    .sel(sel_side[SIDE_S]), .y(route[SIDE_S])
  );
  switch_box_track_mux #(.W(W)) u_mux_w (
    .in0(bus.north_in), .in1(bus.east_in), .in2(bus.south_in),
    .sel(sel_side[SIDE_W]), .y(route[SIDE_W])
  );

  logic [3:0][W-1:0] out_val;

`ifdef SWITCH_BOX_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) out_val <= '0;
    else     out_val <= route;
  end
`else
  assign out_val = route;
`endif

  assign bus.north_out = out_val[SIDE_N];
  assign bus.east_out  = out_val[SIDE_E];
  assign bus.south_out = out_val[SIDE_S];
  assign bus.west_out  = out_val[SIDE_W];
  assign bus.cfg_out   = shadow[NBITS-1];
  assign bus.cfg_full  = full;
  assign bus.cfg_err   = err;

endmodule

// File: tb/tb_switch_box_element_cfg.sv
// Directed, table-driven bench for switch_box_element_cfg (W=4), including a 2-box chain.
module tb_switch_box_element_cfg;

  localparam int unsigned W = 4;
`ifdef SWITCH_BOX_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chain = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  switch_box_element_cfg_if #(.W(W)) b0 ();
  switch_box_element_cfg_if #(.W(W)) b1 ();

  assign b1.cfg_in   = b0.cfg_out;
  assign b1.cfg_en   = b0.cfg_en & chain;
  assign b1.cfg_load = b0.cfg_load & chain;

  switch_box_element_cfg #(.W(W)) u0 (.clk(clk), .rst(rst), .bus(b0));
  switch_box_element_cfg #(.W(W)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct packed {
    logic [31:0] cfg;
    logic [3:0]  n, e, s, w;
    logic [3:0]  xn, xe, xs, xw;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    repeat (LAT) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out0(input string name, input logic [15:0] exp);
    chk({name, ".north"}, 32'(b0.north_out), 32'(exp[15:12]));
    chk({name, ".east"},  32'(b0.east_out),  32'(exp[11:8]));
    chk({name, ".south"}, 32'(b0.south_out), 32'(exp[7:4]));
    chk({name, ".west"},  32'(b0.west_out),  32'(exp[3:0]));
  endtask

  task automatic drive0(input logic [3:0] n, input logic [3:0] e, input logic [3:0] s, input logic [3:0] w);
    b0.north_in = n; b0.east_in = e; b0.south_in = s; b0.west_in = w;
  endtask

  task automatic shift1(input logic b);
    b0.cfg_in = b;
    b0.cfg_en = 1'b1;
    tick();
    b0.cfg_en = 1'b0;
  endtask

  task automatic pulse_load();
    b0.cfg_load = 1'b1;
    tick();
    b0.cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] cfg);
    for (int i = 31; i >= 1; i--) shift1(cfg[i]);
    chk("full_after_31", 32'(b0.cfg_full), 32'd0);
    shift1(cfg[0]);
    chk("full_after_32", 32'(b0.cfg_full), 32'd1);
    pulse_load();
    chk("full_after_load", 32'(b0.cfg_full), 32'd0);
    chk("err_after_load", 32'(b0.cfg_err), 32'd0);
  endtask

  // Reference routing: side d, sel k picks side (d+1+k) mod 4; 3 is OFF.
  function automatic logic [15:0] route(input logic [31:0] cfg, input logic [3:0] n,
                                        input logic [3:0] e, input logic [3:0] s, input logic [3:0] w);
    logic [3:0] src [4];
    logic [3:0] o [4];
    logic [1:0] k;
    src[0] = n; src[1] = e; src[2] = s; src[3] = w;
    for (int d = 0; d < 4; d++) begin
      o[d] = 4'h0;
      for (int t = 0; t < 4; t++) begin
        k = cfg[8*t + 2*d +: 2];
        if (k != 2'd3) o[d][t] = src[(d + 1 + int'(k)) % 4][t];
      end
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  initial begin
    logic [31:0] cfg_b;
    logic [31:0] cfg_c;
    logic [63:0] seq;
    logic [3:0]  rn, re, rs, rw;

    vecs[0] = '{32'h00000000, 4'h3, 4'hA, 4'h5, 4'hC, 4'hA, 4'h5, 4'hC, 4'h3};
    vecs[1] = '{32'hFFFFFFE4, 4'hE, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
    vecs[2] = '{32'hFFFFFFE4, 4'h0, 4'h0, 4'hF, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    vecs[3] = '{32'hFFFFFFE4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[4] = '{32'h55555555, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h8, 4'h1, 4'h2};
    vecs[5] = '{32'hAAAAAAAA, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h1, 4'h2, 4'h4};
    vecs[6] = '{32'hFFAA5500, 4'hF, 4'h0, 4'hF, 4'h0, 4'h2, 4'h5, 4'h2, 4'h5};
    vecs[7] = '{32'hFFAA5500, 4'h0, 4'hF, 4'h0, 4'hF, 4'h5, 4'h2, 4'h5, 4'h2};
    vecs[8] = '{32'hFFFFFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};

    b0.cfg_en = 1'b0; b0.cfg_in = 1'b0; b0.cfg_load = 1'b0;
    drive0(4'hF, 4'hF, 4'hF, 4'hF);
    b1.north_in = 4'hF; b1.east_in = 4'hF; b1.south_in = 4'hF; b1.west_in = 4'hF;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_out0("reset_out", 16'h0000);
    chk("reset_cfg_out", 32'(b0.cfg_out), 32'd1);
    chk("reset_full", 32'(b0.cfg_full), 32'd0);
    chk("reset_err", 32'(b0.cfg_err), 32'd0);

    // Table-driven routing
    for (int i = 0; i < 9; i++) begin
      load_cfg(vecs[i].cfg);
      drive0(vecs[i].n, vecs[i].e, vecs[i].s, vecs[i].w);
      settle();
      chk_out0($sformatf("vec%0d", i), {vecs[i].xn, vecs[i].xe, vecs[i].xs, vecs[i].xw});
    end

    // Early commit: rejected, sticky error, routing untouched
    load_cfg(32'h00000000);
    drive0(4'h3, 4'hA, 4'h5, 4'hC);
    cfg_b = 32'h55555555;
    for (int i = 31; i >= 22; i--) shift1(cfg_b[i]);
    pulse_load();
    chk("early_err", 32'(b0.cfg_err), 32'd1);
    chk("early_full", 32'(b0.cfg_full), 32'd0);
    settle();
    chk_out0("early_out", 16'hA5C3);
    for (int i = 21; i >= 0; i--) shift1(cfg_b[i]);
    chk("early_full_32", 32'(b0.cfg_full), 32'd1);
    chk("early_err_hold", 32'(b0.cfg_err), 32'd1);
    pulse_load();
    chk("late_err_sticky", 32'(b0.cfg_err), 32'd1);
    chk("late_full_clr", 32'(b0.cfg_full), 32'd0);
    settle();
    chk_out0("late_out", 16'h5C3A);

    // Glitch-free reload: shifting C must not disturb active B
    cfg_c = 32'hAAAAAAAA;
    for (int i = 31; i >= 0; i--) begin
      shift1(cfg_c[i]);
      rn = 4'($urandom); re = 4'($urandom); rs = 4'($urandom); rw = 4'($urandom);
      drive0(rn, re, rs, rw);
      settle();
      chk_out0("hold_B", route(cfg_b, rn, re, rs, rw));
    end
    b0.cfg_in = 1'b1;
    b0.cfg_en = 1'b1;
    b0.cfg_load = 1'b1;
    tick();
    b0.cfg_en = 1'b0;
    b0.cfg_load = 1'b0;
    drive0(4'h1, 4'h2, 4'h4, 4'h8);
    settle();
    chk_out0("commit_C", 16'h8124);
    for (int i = 0; i < 30; i++) shift1(1'b1);
    chk("cnt1_full_31", 32'(b0.cfg_full), 32'd0);
    shift1(1'b1);
    chk("cnt1_full_32", 32'(b0.cfg_full), 32'd1);

    // Two-box chain: first-shifted word lands downstream
    rst = 1'b1; tick(); rst = 1'b0;
    chain = 1'b1;
    seq = {32'h00000000, 32'h55555555};
    for (int i = 63; i >= 0; i--) shift1(seq[i]);
    chk("chain_full1", 32'(b1.cfg_full), 32'd1);
    pulse_load();
    chain = 1'b0;
    drive0(4'h3, 4'hA, 4'h5, 4'hC);
    b1.north_in = 4'h3; b1.east_in = 4'hA; b1.south_in = 4'h5; b1.west_in = 4'hC;
    settle();
    chk_out0("chain_u0", 16'h5C3A);
    chk("chain_u1.north", 32'(b1.north_out), 32'hA);
    chk("chain_u1.east",  32'(b1.east_out),  32'h5);
    chk("chain_u1.south", 32'(b1.south_out), 32'hC);
    chk("chain_u1.west",  32'(b1.west_out),  32'h3);
    chk("chain_err1", 32'(b1.cfg_err), 32'd0);

    // Reset mid-shift discards partial stream and active config
    for (int i = 0; i < 15; i++) shift1(1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk_out0("midrst_out", 16'h0000);
    chk("midrst_full", 32'(b0.cfg_full), 32'd0);
    chk("midrst_cfg_out", 32'(b0.cfg_out), 32'd1);
    for (int i = 0; i < 31; i++) shift1(1'b0);
    chk("midrst_full_31", 32'(b0.cfg_full), 32'd0);
    shift1(1'b0);
    chk("midrst_full_32", 32'(b0.cfg_full), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
